// File: rtl/csla_stream_accum.sv
// csla_stream_accum: burst accumulator built around a 16-bit carry-select adder.
// A burst of `len` words arrives over a valid/ready input. The words are summed
// modulo 2^16 at one word per cycle. The final sum and a sticky wrap flag are
// then presented over a valid/ready output.

// ---------------------------------------------------------------------------
// csla_add16: 16-bit carry-select adder with no carry-in and no carry-out.
// The operand is split into 4-bit blocks. Every block above block 0 computes
// its sum and carry for both possible carry-ins. The real carry arriving from
// the block below selects which of the two results is used.
// ---------------------------------------------------------------------------
module csla_add16 #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  localparam int NBLK = WIDTH / BLK;

  // Ripple-carry sum of one block for a given carry-in.
  function automatic logic [BLK-1:0] blk_sum(input logic [BLK-1:0] a,
                                             input logic [BLK-1:0] b,
                                             input logic           cin);
    logic c;
    // NOTE: blocking assignments here: the carry must ripple bit to bit
    // within a single evaluation, so each line must see the previous update.
    c = cin;
    for (int k = 0; k < BLK; k++) begin
      blk_sum[k] = a[k] ^ b[k] ^ c;
      c          = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
  endfunction

  // Ripple-carry carry-out of one block for a given carry-in.
  function automatic logic blk_cout(input logic [BLK-1:0] a,
                                    input logic [BLK-1:0] b,
                                    input logic           cin);
    logic c;
    c = cin;
    for (int k = 0; k < BLK; k++) begin
      c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    blk_cout = c;
  endfunction

  // w_cin[g] is the selected carry entering block g.
  logic [NBLK-1:0] w_cin;

  assign w_cin[0] = 1'b0;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK-1:0] w_a;
    logic [BLK-1:0] w_b;
    logic [BLK-1:0] w_sum0;
    logic [BLK-1:0] w_sum1;

    assign w_a    = i_a[g*BLK +: BLK];
    assign w_b    = i_b[g*BLK +: BLK];
    assign w_sum0 = blk_sum(w_a, w_b, 1'b0);
    assign w_sum1 = blk_sum(w_a, w_b, 1'b1);

    assign o_sum[g*BLK +: BLK] = w_cin[g] ? w_sum1 : w_sum0;

    // The top block's carry would be the adder carry-out, which is not needed.
    if (g < NBLK - 1) begin : g_carry
      logic w_cout0;
      logic w_cout1;
      assign w_cout0      = blk_cout(w_a, w_b, 1'b0);
      assign w_cout1      = blk_cout(w_a, w_b, 1'b1);
      assign w_cin[g + 1] = w_cin[g] ? w_cout1 : w_cout0;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// csla_stream_accum: top level.
// ---------------------------------------------------------------------------
module csla_stream_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_wrap,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_acc;
  logic             r_wrap;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_wrap;

  logic [WIDTH-1:0] w_add_sum;
  logic             w_wrap_nxt;
  logic             w_beat;
  logic             w_last;
  logic             w_launch;

  // The adder is fed straight from the accumulator and the input port, so one
  // word can be accepted every cycle.
  csla_add16 #(
    .WIDTH (WIDTH),
    .BLK   (4)
  ) u_add (
    .i_a   (r_acc),
    .i_b   (in_data),
    .o_sum (w_add_sum)
  );

  // The adder has no carry-out. A sum that is smaller than the old
  // accumulator value means the addition wrapped past 2^WIDTH.
  assign w_wrap_nxt = r_wrap | (w_add_sum < r_acc);
  assign w_beat     = in_valid & in_ready;
  assign w_last     = (r_cnt == CNT_W'(1));
  assign w_launch   = (r_state == S_IDLE) & start;

  assign out_sum    = r_out_sum;
  assign out_wrap   = r_out_wrap;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state, so every register samples
    // values from before the edge regardless of statement order.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (w_beat && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Accumulator, counter and wrap flag. The result registers are loaded when
  // the machine enters DONE and hold their value afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_wrap     <= 1'b0;
      r_cnt      <= '0;
      r_out_sum  <= '0;
      r_out_wrap <= 1'b0;
    end else begin
      if (w_launch) begin
        r_acc  <= '0;
        r_wrap <= 1'b0;
        if (len != '0) begin
          r_cnt <= len;
        end else begin
          // An empty burst goes straight to DONE with a zero result.
          r_out_sum  <= '0;
          r_out_wrap <= 1'b0;
        end
      end
      if (w_beat) begin
        r_acc  <= w_add_sum;
        r_wrap <= w_wrap_nxt;
        r_cnt  <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_out_sum  <= w_add_sum;
          r_out_wrap <= w_wrap_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_csla_stream_accum.sv
// Self-checking bench for csla_stream_accum. Expected results are computed
// from the words of each burst and queued when the burst is driven. They are
// popped and compared when the DUT presents its result.
module tb_csla_stream_accum;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_wrap;
  logic             busy;

  always #5 clk = ~clk;

  csla_stream_accum #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_wrap  (out_wrap),
    .busy      (busy)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             wrap;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] words[$];
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a 17-bit add, where bit 16 is the carry that the DUT does not have.
  task automatic push_expected();
    logic [WIDTH:0] s;
    exp_t           e;
    e = '0;
    foreach (words[i]) begin
      s      = {1'b0, e.sum} + {1'b0, words[i]};
      e.wrap = e.wrap | s[WIDTH];
      e.sum  = s[WIDTH-1:0];
    end
    sb_q.push_back(e);
  endtask

  // Call this at posedge+1 with the DUT in IDLE. It returns at posedge+1 after the start edge.
  task automatic do_start(input int n);
    start = 1'b1;
    len   = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = CNT_W'($urandom);
  endtask

  // Drive every word in `words`. With gaps set, insert one idle cycle between
  // words. With poke set, pulse start (len=7) during each of those idle cycles.
  task automatic feed(input bit gaps, input bit poke);
    foreach (words[i]) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        if (poke) begin
          start = 1'b1;
          len   = CNT_W'(7);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = words[i];
      begin
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
          @(negedge clk);
          t++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  // Call this at posedge+1 after the edge that took the last beat. It holds
  // out_ready low for `stall` cycles, then takes the result. With poke set,
  // start is held high for the whole time, including the accept cycle.
  task automatic collect(input int stall, input bit poke);
    exp_t e;
    out_ready = (stall == 0);
    if (poke) begin
      start = 1'b1;
      len   = CNT_W'(3);
    end
    @(negedge clk);
    check("out_valid_latency", 32'(out_valid), 32'd1);
    if (!out_valid) begin
      int t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        start     = 1'b0;
        return;
      end
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("out_sum", 32'(out_sum), 32'(e.sum));
    check("out_wrap", 32'(out_wrap), 32'(e.wrap));
    check("in_ready_done", 32'(in_ready), 32'd0);
    check("busy_done", 32'(busy), 32'd1);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_sum", 32'(out_sum), 32'(e.sum));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("out_valid_after_accept", 32'(out_valid), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd0);
    check("out_sum_hold", 32'(out_sum), 32'(e.sum));
  endtask

  task automatic run_burst(input int stall, input bit gaps, input bit poke);
    @(posedge clk); #1;
    push_expected();
    do_start(words.size());
    feed(gaps, poke);
    collect(stall, poke);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_wrap", 32'(out_wrap), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Basic burst: 1+2+3+4.
    words = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_burst(0, 1'b0, 1'b0);

    // Empty burst.
    words = {};
    run_burst(0, 1'b0, 1'b0);

    // Gapped valid (1,0,1,0,1) and a five-cycle output stall.
    words = {16'h1111, 16'h2222, 16'h3333};
    run_burst(5, 1'b1, 1'b0);

    // Wrap past 2^16.
    words = {16'hFFFF, 16'h0003};
    run_burst(0, 1'b0, 1'b0);

    // Reset in mid-burst, asserted together with in_valid.
    @(posedge clk); #1;
    do_start(5);
    in_valid = 1'b1;
    in_data  = 16'h1000;
    @(posedge clk); #1;
    in_data  = 16'h2000;
    @(posedge clk); #1;
    in_data  = 16'h3000;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    check("midrst_out_wrap", 32'(out_wrap), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_idle_hold", 32'(busy), 32'd0);
    words = {16'h1234};
    run_burst(0, 1'b0, 1'b0);

    // Start pulses during ACCUM and DONE must be ignored.
    words = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
    run_burst(2, 1'b1, 1'b1);

    // Longest burst: 255 x 0x0101 = 0xFFFF, with no wrap.
    words = {};
    for (int i = 0; i < 255; i++) words.push_back(16'h0101);
    run_burst(0, 1'b0, 1'b0);

    // Random bursts.
    for (int b = 0; b < 4; b++) begin
      int n;
      n = $urandom_range(1, 20);
      words = {};
      for (int i = 0; i < n; i++) words.push_back(WIDTH'($urandom));
      run_burst($urandom_range(0, 3), 1'(b % 2), 1'b0);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csla_stream_accum.md
Name: csla_stream_accum

Overview:
- Sequential accumulator stage that feeds the 16-bit carry-select adder (no carry-out) and consumes its result.
- Accepts a burst of LEN 16-bit words over a valid/ready input, and sums them modulo 2^16 through one instance of the team's 16-bit carry-select adder.
- Presents the final sum with a sticky wrap flag over a valid/ready output.
- Sits between the operand source (memory/sample interface) and downstream result consumers.

Parameters:
- WIDTH, 16, data/accumulator width; must match the adder instance and is fixed at 16 for this block.
- CNT_W, 8, width of burst-length counter; max burst is 2^CNT_W - 1 words.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  begin a burst; honoured only in IDLE.
- len  input  CNT_W  burst length in words, sampled with start.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  sum of burst modulo 2^16.
- out_wrap  output  1  sticky: at least one addition in the burst wrapped past 2^16.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; acc=0; cnt=0; wrap=0.
  - in_ready=0, out_valid=0, out_sum=0, out_wrap=0, busy=0.
  - Reset mid-burst discards the partial sum; no output is produced for that burst.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with len!=0: acc<=0, wrap<=0, cnt<=len, next state ACCUM.
  - start=1 with len==0: acc<=0, wrap<=0, next state DONE. The result is sum 0, no wrap.
  - start=0: stay in IDLE.
- ACCUM:
  - in_ready=1.
  - Beat = in_valid & in_ready.
  - On a beat: acc <= adder(acc, in_data), the lower 16 bits only.
  - On a beat: wrap <= wrap | (adder result < acc), an unsigned compare that recovers the missing carry.
  - On a beat: cnt <= cnt-1.
  - If a beat occurs with cnt==1, next state DONE.
  - No beat: hold all state.
  - start is ignored in this state.
- Adder path:
  - The adder is fed directly from the acc register and the in_data port; it is combinational.
  - Its result is registered into acc on the same edge that accepts the beat.
  - Throughput is one word per cycle.
- DONE:
  - out_valid=1, out_sum=acc, out_wrap=wrap.
  - in_ready=0.
  - Outputs stay stable while out_ready=0.
  - When out_valid & out_ready: next state IDLE, out_valid deasserts next cycle.
  - start in DONE is ignored, even in the cycle the result is accepted. A new burst needs start in IDLE.
- Latency: out_valid rises on the cycle after the edge that accepted the last beat. A len=0 burst gives out_valid one cycle after start.
- Outside DONE: out_sum and out_wrap hold their last values. They are reset to 0 only by rst_n.
- Width rules:
  - Sum is modulo 2^16.
  - cnt is unsigned. len is never negative, and the maximum is 255 when CNT_W=8.
- Simultaneous in_valid and rst_n=0: reset wins; the word is not accepted.
- in_data is don't-care when in_valid=0.

Test Plan:
- Reset then start, len=4, data 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th beat, out_sum=0x000A, out_wrap=0, then IDLE.
- len=2, data 0xFFFF then 0x0003 -> out_sum=0x0002, out_wrap=1.
- len=3 with in_valid toggled 1,0,1,0,1, and out_ready held 0 for 5 cycles after DONE -> out_sum stays 0x(sum) stable, out_valid stays 1, in_ready=0 in DONE.
- start with len=0 -> out_valid next cycle, out_sum=0x0000, out_wrap=0.
- Start len=5, accept 2 words, drive rst_n=0 for one cycle -> all outputs 0, state IDLE. Then a new burst len=1, data 0x1234 -> out_sum=0x1234.
- start pulsed during ACCUM and DONE -> ignored; burst count unchanged. Also len=255 of 0x0101 -> out_sum=0xFFFF, out_wrap=0.
